// File: rtl/rvx10_mc_ctrl.sv
// rvx10_mc_ctrl: Moore control FSM that steps the shared RVX10 multicycle datapath through fetch/decode/execute.
// Latency: 3 cycles (beq) to 5 cycles (lw) per instruction plus memory wait cycles; outputs decode from state.
// Backpressure: MemReady low holds FETCH, MEMRD and MEMWR in place; no register write is issued while waiting.
//
// Ports: clk/reset (async, active-high); op/funct3/funct7b5/funct7_2b from IR; Zero from ALU;
//        MemReady from the memory port; PCWrite/AdrSrc/MemWrite/IRWrite/ResultSrc/ALUSrcA/ALUSrcB/
//        ImmSrc/RegWrite/ALUControl steer the datapath; Illegal is the trap flag; InstRet counts retirements.

// aludec: ALU operation decoder, shared by base RV32I ops and RVX10 custom-0 ops.
// Combinational, zero latency; no handshake.
// Ports: i_opb5/i_funct3/i_funct7b5/i_funct7_2b from IR, i_alu_op from the FSM, o_alu_control to the ALU.
module aludec (
    input  logic       i_opb5,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic [1:0] i_funct7_2b,
    input  logic [1:0] i_alu_op,
    output logic [3:0] o_alu_control
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            2'b00: o_alu_control = ALU_ADD;
            2'b01: o_alu_control = ALU_SUB;
            2'b10: begin
                case (i_funct3)
                    // sub only for R-type (op[5]=1); addi ignores imm bit 30
                    3'b000:  o_alu_control = (i_funct7b5 & i_opb5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: begin
                // RVX10 ops occupy codes 0110..1111 in {funct7_2b, funct3} order
                case ({i_funct7_2b, i_funct3})
                    5'b00_000: o_alu_control = 4'b0110; // andn
                    5'b00_001: o_alu_control = 4'b0111; // orn
                    5'b00_010: o_alu_control = 4'b1000; // xnor
                    5'b01_000: o_alu_control = 4'b1001; // min
                    5'b01_001: o_alu_control = 4'b1010; // max
                    5'b01_010: o_alu_control = 4'b1011; // minu
                    5'b01_011: o_alu_control = 4'b1100; // maxu
                    5'b10_000: o_alu_control = 4'b1101; // rol
                    5'b10_001: o_alu_control = 4'b1110; // ror
                    5'b11_000: o_alu_control = 4'b1111; // abs
                    default:   o_alu_control = ALU_ADD;
                endcase
            end
        endcase
    end
endmodule

module rvx10_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [1:0]       funct7_2b,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic [3:0]       ALUControl,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_RVX = 7'b0001011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_EXECX, S_ALUWB, S_JAL, S_BEQ, S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic [1:0]       w_alu_op;
    logic             w_pc_update;
    logic             w_branch;
    logic             w_ir_write;
    logic             w_mem_write;
    logic             w_reg_write;
    logic             w_rvx_legal;
    logic             w_retire;

    // Populated RVX10 slots: 3, 4, 2 and 1 ops for funct7_2b = 00, 01, 10, 11.
    always_comb begin
        case (funct7_2b)
            2'b00:   w_rvx_legal = (funct3 <= 3'd2);
            2'b01:   w_rvx_legal = (funct3 <= 3'd3);
            2'b10:   w_rvx_legal = (funct3 <= 3'd1);
            default: w_rvx_legal = (funct3 == 3'd0);
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_ir_write  = MemReady;
                w_pc_update = MemReady;
                if (MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_RVX:       w_next = w_rvx_legal ? S_EXECX : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (MemReady) w_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECX: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b11;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                // ALU forms OldPC+4 for rd while PC takes the jump target
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are gated by reset directly so an abandoned access cannot write while reset is held.
    assign PCWrite  = ~reset & (w_pc_update | (w_branch & Zero));
    assign IRWrite  = ~reset & w_ir_write;
    assign MemWrite = ~reset & w_mem_write;
    assign RegWrite = ~reset & w_reg_write;
    assign Illegal  = (r_state == S_TRAP);

    // jal passes through ALUWB, so it is counted there and not at S_JAL.
    assign w_retire = (r_state == S_MEMWB) | (r_state == S_ALUWB) | (r_state == S_BEQ)
                    | ((r_state == S_MEMWR) & MemReady);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign InstRet = r_instret;

    aludec u_aludec (
        .i_opb5        (op[5]),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_funct7_2b   (funct7_2b),
        .i_alu_op      (w_alu_op),
        .o_alu_control (ALUControl)
    );
endmodule
